restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 112 +++++++++++
 tb/tb_restoring_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider (SHIFT/SUB/CHECK per quotient bit)
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                m_d   = divisor;
                cnt_d = CNT_W'(WIDTH);
                dbz_d = (divisor == '0);
                if (divisor == '0) begin
                    // Zero divisor short-circuits to the all-ones / pass-through result.
                    q_d     = '1;
                    a_d     = {1'b0, dividend};
                    state_d = S_DONE;
                end else begin
                    q_d     = dividend;
                    a_d     = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
                state_d    = S_SUB;
            end
            S_SUB: begin
                a_d     = a_q - {1'b0, m_q};
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Negative trial remainder means the divisor did not fit: restore it.
                if (a_q[WIDTH]) begin
                    a_d    = a_q + {1'b0, m_q};
                    q_d[0] = 1'b0;
                end else begin
                    q_d[0] = 1'b1;
                end
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient    = q_q;
    assign remainder   = a_q[WIDTH-1:0];
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed and random self-checking bench for restoring_divider
module tb_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  overlap_seen = 1'b0;

    restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns the number of edges after the start-sampling edge until done is seen.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input bit hold, input bit scramble, output int edges);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (scramble && edges == 2) begin
                dividend = ~a;
                divisor  = b + 8'd3;
                start    = 1'b1;
            end
            if (scramble && edges == 4 && !hold) start = 1'b0;
        end
    endtask

    task automatic to_idle();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int edges;
        logic [7:0] ra, rb;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 25};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 25};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 25};
        vecs[3] = '{8'h5A,  8'd0,   8'hFF,  8'h5A, 1'b1, 1};
        vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 25};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 25};
        vecs[6] = '{8'd200, 8'd16,  8'd12,  8'd8,  1'b0, 25};

        rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst_busy", busy, 0);

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0, 1'b0, edges);
            check($sformatf("lat_%0d", i), edges, vecs[i].lat);
            check($sformatf("quot_%0d", i), quotient, vecs[i].q);
            check($sformatf("rem_%0d", i), remainder, vecs[i].r);
            check($sformatf("dbz_%0d", i), div_by_zero, vecs[i].z);
            to_idle();
            check($sformatf("idle_hold_quot_%0d", i), quotient, vecs[i].q);
            check($sformatf("idle_done_%0d", i), done, 0);
        end

        // Hold start through completion, then release.
        run_div(8'd100, 8'd7, 1'b1, 1'b0, edges);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_quot", quotient, 14);
        start = 1'b0;
        @(posedge clk); #1;
        check("release_done", done, 0);
        check("release_busy", busy, 0);
        check("release_rem", remainder, 2);

        // Operands and start disturbed while busy.
        run_div(8'd200, 8'd16, 1'b0, 1'b1, edges);
        check("scr_lat", edges, 25);
        check("scr_quot", quotient, 12);
        check("scr_rem", remainder, 8);
        to_idle();

        // Reset in the middle of a division.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_quot", quotient, 0);
        check("midrst_rem", remainder, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_busy", busy, 0);
        check("midrst_idle_done", done, 0);
        run_div(8'd200, 8'd16, 1'b0, 1'b0, edges);
        check("post_rst_quot", quotient, 12);
        check("post_rst_rem", remainder, 8);
        to_idle();

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_div(ra, rb, 1'b0, 1'b0, edges);
            check($sformatf("rnd_%0d_%0d/%0d", k, ra, rb),
                  {quotient, remainder}, {ra / rb, ra % rb});
            to_idle();
        end
        check("busy_done_overlap", overlap_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
